// File: rtl/uart_avmm_bridge_pkg.sv
// Shared types and constants for the UART byte-stream to Avalon-MM bridge.
// Includes the byte-wide CRC8 step used by both the receive check and the response generator.
package uart_avmm_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CRC,
      S_BUS,
      S_RSP_HDR,
      S_RSP_STAT,
      S_RSP_DATA,
      S_RSP_CRC
   } state_e;

   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_CRC     = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'h02;
   localparam logic [7:0] CRC8_POLY  = 8'h07;

   // MSB-first, no reflection, no final xor.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_avmm_bridge_if.sv
// Byte-stream in/out plus Avalon-MM master signals of the bridge.
// The master modport is the bridge side; slave is the UART/interconnect side.
interface uart_avmm_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [7:0]        avsi_data;
   logic              avsi_valid;
   logic              avsi_ready;
   logic [7:0]        avso_data;
   logic              avso_valid;
   logic              avso_ready;
   logic [ADDR_W-1:0] avmm_address;
   logic              avmm_write;
   logic              avmm_read;
   logic [DATA_W-1:0] avmm_writedata;
   logic [DATA_W-1:0] avmm_readdata;
   logic              avmm_waitrequest;

   modport master (
      input  avsi_data, avsi_valid, avso_ready, avmm_readdata, avmm_waitrequest,
      output avsi_ready, avso_data, avso_valid, avmm_address, avmm_write, avmm_read,
             avmm_writedata
   );

   modport slave (
      output avsi_data, avsi_valid, avso_ready, avmm_readdata, avmm_waitrequest,
      input  avsi_ready, avso_data, avso_valid, avmm_address, avmm_write, avmm_read,
             avmm_writedata
   );
endinterface

// File: rtl/uart_avmm_bridge_crc8.sv
// Byte-wide CRC8 accumulator; clr restarts from zero and may coincide with en
// so the first byte of a new sequence is folded in the same cycle.
module uart_crc8
   import uart_avmm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] crc
);
   logic [7:0] crc_q, crc_d, base;

   always_comb begin
      base  = clr ? 8'h00 : crc_q;
      crc_d = en ? crc8_byte(base, din) : base;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) crc_q <= 8'h00;
      else          crc_q <= crc_d;
   end

   assign crc = crc_q;
endmodule

// File: rtl/uart_avmm_bridge.sv
// UART byte-stream to Avalon-MM master bridge: parses SYNC/CMD/ADDR/DATA/CRC frames,
// runs one bus access per good frame and returns a CRC-protected status response.
module uart_avmm_bridge
   import uart_avmm_pkg::*;
#(
   parameter int         ADDR_W       = 32,
   parameter int         DATA_W       = 32,
   parameter int         BYTE_TIMEOUT = 50_000_000,
   parameter int         BUS_TIMEOUT  = 50_000_000,
   parameter logic [7:0] SYNC_BYTE    = 8'hFF,
   parameter logic [7:0] RSP_BYTE     = 8'hFE
) (
   input logic                clk,
   input logic                reset_n,
   uart_avmm_bridge_if.master bus
);
   localparam int ADDR_B = ADDR_W / 8;
   localparam int DATA_B = DATA_W / 8;
   localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
   localparam int CNT_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;
   localparam int BYT_W  = $clog2(BYTE_TIMEOUT + 1);
   localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);
   localparam int TMR_W  = (BYT_W > BUS_W) ? BYT_W : BUS_W;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_B - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_B - 1);
   localparam logic [TMR_W-1:0] BYTE_LAST = TMR_W'(BYTE_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] BUS_LAST  = TMR_W'(BUS_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              is_read_q, is_read_d;
   logic [7:0]        status_q, status_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              si_ready_q, si_ready_d;
   logic              so_valid_q, so_valid_d;
   logic [7:0]        so_data_q, so_data_d;

   logic       in_acc, out_xfer, in_frame;
   logic       rx_clr, rx_en, tx_clr, tx_en;
   logic [7:0] rx_crc, tx_crc, rd_byte_next;

   assign in_acc   = bus.avsi_valid & si_ready_q;
   assign out_xfer = so_valid_q & bus.avso_ready;
   assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_CRC);

   uart_crc8 u_rx_crc (
      .clk(clk), .reset_n(reset_n), .clr(rx_clr), .en(rx_en),
      .din(bus.avsi_data), .crc(rx_crc)
   );

   // Fed with each status/data byte as it is loaded into the output register,
   // so the running value is complete by the time that byte is taken.
   uart_crc8 u_tx_crc (
      .clk(clk), .reset_n(reset_n), .clr(tx_clr), .en(tx_en),
      .din(so_data_d), .crc(tx_crc)
   );

   always_comb begin
      rd_byte_next = 8'h00;
      for (int i = 1; i < DATA_B; i++) begin
         if (cnt_q == CNT_W'(i - 1)) rd_byte_next = rdata_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      is_read_d  = is_read_q;
      status_d   = status_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      so_valid_d = so_valid_q;
      so_data_d  = so_data_q;
      rx_clr     = 1'b0;
      rx_en      = 1'b0;
      tx_clr     = 1'b0;
      tx_en      = 1'b0;

      if (in_frame) tmr_d = in_acc ? '0 : tmr_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (in_acc && bus.avsi_data == SYNC_BYTE) begin
               state_d = S_CMD;
               rx_clr  = 1'b1;
               tmr_d   = '0;
            end
         end
         S_CMD: begin
            if (in_acc) begin
               rx_en = 1'b1;
               cnt_d = '0;
               if (bus.avsi_data == CMD_WRITE || bus.avsi_data == CMD_READ) begin
                  state_d   = S_ADDR;
                  is_read_d = (bus.avsi_data == CMD_READ);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_ADDR: begin
            if (in_acc) begin
               rx_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               for (int i = 0; i < ADDR_B; i++) begin
                  if (cnt_q == CNT_W'(i)) addr_d[8*i +: 8] = bus.avsi_data;
               end
               if (cnt_q == ADDR_LAST) begin
                  cnt_d   = '0;
                  state_d = is_read_q ? S_CRC : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (in_acc) begin
               rx_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               for (int i = 0; i < DATA_B; i++) begin
                  if (cnt_q == CNT_W'(i)) wdata_d[8*i +: 8] = bus.avsi_data;
               end
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = S_CRC;
               end
            end
         end
         S_CRC: begin
            if (in_acc) begin
               if (bus.avsi_data == rx_crc) begin
                  state_d = S_BUS;
                  wr_d    = !is_read_q;
                  rd_d    = is_read_q;
                  tmr_d   = '0;
               end else begin
                  state_d    = S_RSP_HDR;
                  status_d   = ST_CRC;
                  so_valid_d = 1'b1;
                  so_data_d  = RSP_BYTE;
               end
            end
         end
         S_BUS: begin
            // A completing access beats a timeout that lands on the same cycle.
            if (!bus.avmm_waitrequest) begin
               if (is_read_q) rdata_d = bus.avmm_readdata;
               wr_d       = 1'b0;
               rd_d       = 1'b0;
               status_d   = ST_OK;
               state_d    = S_RSP_HDR;
               so_valid_d = 1'b1;
               so_data_d  = RSP_BYTE;
            end else if (tmr_q == BUS_LAST) begin
               wr_d       = 1'b0;
               rd_d       = 1'b0;
               status_d   = ST_TIMEOUT;
               state_d    = S_RSP_HDR;
               so_valid_d = 1'b1;
               so_data_d  = RSP_BYTE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_RSP_HDR: begin
            if (out_xfer) begin
               state_d   = S_RSP_STAT;
               so_data_d = status_q;
               tx_clr    = 1'b1;
               tx_en     = 1'b1;
            end
         end
         S_RSP_STAT: begin
            if (out_xfer) begin
               if (is_read_q && status_q == ST_OK) begin
                  state_d   = S_RSP_DATA;
                  cnt_d     = '0;
                  so_data_d = rdata_q[7:0];
                  tx_en     = 1'b1;
               end else begin
                  state_d   = S_RSP_CRC;
                  so_data_d = tx_crc;
               end
            end
         end
         S_RSP_DATA: begin
            if (out_xfer) begin
               if (cnt_q == DATA_LAST) begin
                  state_d   = S_RSP_CRC;
                  so_data_d = tx_crc;
               end else begin
                  cnt_d     = cnt_q + 1'b1;
                  so_data_d = rd_byte_next;
                  tx_en     = 1'b1;
               end
            end
         end
         S_RSP_CRC: begin
            if (out_xfer) begin
               state_d    = S_IDLE;
               so_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Silent abandon of a stalled frame; any partial address/data stays latched.
      if (in_frame && !in_acc && tmr_q == BYTE_LAST) state_d = S_IDLE;

      si_ready_d = (state_d == S_IDLE) || (state_d == S_CMD) || (state_d == S_ADDR) ||
                   (state_d == S_DATA) || (state_d == S_CRC);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tmr_q      <= '0;
         is_read_q  <= 1'b0;
         status_q   <= 8'h00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         si_ready_q <= 1'b1;
         so_valid_q <= 1'b0;
         so_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         is_read_q  <= is_read_d;
         status_q   <= status_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         si_ready_q <= si_ready_d;
         so_valid_q <= so_valid_d;
         so_data_q  <= so_data_d;
      end
   end

   assign bus.avsi_ready     = si_ready_q;
   assign bus.avso_valid     = so_valid_q;
   assign bus.avso_data      = so_data_q;
   assign bus.avmm_address   = addr_q;
   assign bus.avmm_writedata = wdata_q;
   assign bus.avmm_write     = wr_q;
   assign bus.avmm_read      = rd_q;
endmodule

// File: tb/tb_uart_avmm_bridge.sv
// Scoreboard bench for uart_avmm_bridge: directed frames push expected response bytes
// and bus accesses; independent monitors pop and compare as the DUT presents them.
module tb_uart_avmm_bridge;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int BYTE_TO = 100;
   localparam int BUS_TO  = 64;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;
   } bus_exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uart_avmm_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   uart_avmm_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_TIMEOUT(BYTE_TO), .BUS_TIMEOUT(BUS_TO),
      .SYNC_BYTE(8'hFF), .RSP_BYTE(8'hFE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_if.master)
   );

   bq_t         rsp_q;
   bus_exp_t    bus_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          rx_cnt = 0;
   bit          rand_ready = 1'b0;
   int          ws_target = 0;
   int          ws_cnt = 0;
   logic [31:0] rdata_val = 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name, input string info);
      n_chk++;
      n_fail++;
      $display("FAIL %s: %s", name, info);
   endtask

   // Bit-serial reference CRC8 (poly 0x07, init 0).
   function automatic logic [7:0] crc8(input bq_t b);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      foreach (b[i]) begin
         for (int k = 7; k >= 0; k--) begin
            fb = c[7] ^ b[i][k];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c;
   endfunction

   function automatic bq_t mk_frame(input logic [7:0] cmd, input logic [31:0] a,
                                    input logic [31:0] d, input logic [7:0] flip);
      bq_t p, f;
      p.push_back(cmd);
      for (int i = 0; i < 4; i++) p.push_back(8'(a >> (8 * i)));
      if (cmd == 8'h01) for (int i = 0; i < 4; i++) p.push_back(8'(d >> (8 * i)));
      f.push_back(8'hFF);
      foreach (p[i]) f.push_back(p[i]);
      f.push_back(crc8(p) ^ flip);
      return f;
   endfunction

   task automatic push_read_rsp(input logic [31:0] d);
      bq_t p;
      p.push_back(8'h00);
      for (int i = 0; i < 4; i++) p.push_back(8'(d >> (8 * i)));
      rsp_q.push_back(8'hFE);
      foreach (p[i]) rsp_q.push_back(p[i]);
      rsp_q.push_back(crc8(p));
   endtask

   task automatic push_bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int len);
      bus_exp_t e;
      e.wr = wr; e.addr = a; e.wdata = d; e.len = len;
      bus_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      bus_if.avsi_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus_if.avsi_data  = b;
      bus_if.avsi_valid = 1'b1;
      n = 0;
      while (!bus_if.avsi_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_evt("send_byte", "avsi_ready never rose within 3000 cycles");
      @(negedge clk);
      bus_if.avsi_valid = 1'b0;
   endtask

   task automatic send_frame(input bq_t f, input int gapmax);
      foreach (f[i]) send_byte(f[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) fail_evt(name, "expected traffic not seen within 5000 cycles");
      repeat (5) @(negedge clk);
   endtask

   // Avalon slave: waitrequest held for ws_target cycles of each access.
   initial begin
      bus_if.avmm_waitrequest = 1'b1;
      bus_if.avmm_readdata    = 32'h0;
      forever begin
         @(negedge clk);
         bus_if.avmm_readdata = rdata_val;
         if (bus_if.avmm_write || bus_if.avmm_read) begin
            if (ws_cnt < ws_target) begin
               bus_if.avmm_waitrequest = 1'b1;
               ws_cnt++;
            end else begin
               bus_if.avmm_waitrequest = 1'b0;
            end
         end else begin
            ws_cnt = 0;
            bus_if.avmm_waitrequest = 1'b1;
         end
      end
   end

   // Response monitor: drives avso_ready, then scores any transfer for this cycle.
   initial begin
      logic       stall;
      logic [7:0] held;
      logic [7:0] exp_b;
      stall = 1'b0;
      held  = 8'h00;
      bus_if.avso_ready = 1'b1;
      forever begin
         @(negedge clk);
         bus_if.avso_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (!reset_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("avso_hold_valid", 64'(bus_if.avso_valid), 64'd1);
               chk("avso_hold_data", 64'(bus_if.avso_data), 64'(held));
            end
            if (bus_if.avso_valid && bus_if.avso_ready) begin
               if (rsp_q.size() == 0) begin
                  fail_evt("avso_unexpected", $sformatf("got byte %0h, required none", bus_if.avso_data));
               end else begin
                  exp_b = rsp_q.pop_front();
                  chk("avso_byte", 64'(bus_if.avso_data), 64'(exp_b));
               end
               rx_cnt++;
            end
            stall = bus_if.avso_valid && !bus_if.avso_ready;
            held  = bus_if.avso_data;
         end
      end
   end

   // Bus monitor: checks each access on its rising strobe and its held length on fall.
   initial begin
      logic     prev_s;
      logic     s;
      int       len;
      bus_exp_t cur;
      prev_s = 1'b0;
      len    = 0;
      cur    = '{wr: 1'b0, addr: 32'h0, wdata: 32'h0, len: 0};
      forever begin
         @(negedge clk);
         s = bus_if.avmm_write | bus_if.avmm_read;
         if (!reset_n) begin
            prev_s = 1'b0;
         end else begin
            if (s && !prev_s) begin
               if (bus_q.size() == 0) begin
                  fail_evt("bus_unexpected", $sformatf("access to %0h, required none", bus_if.avmm_address));
               end else begin
                  cur = bus_q.pop_front();
                  chk("bus_write", 64'(bus_if.avmm_write), 64'(cur.wr));
                  chk("bus_read", 64'(bus_if.avmm_read), 64'(!cur.wr));
                  chk("bus_addr", 64'(bus_if.avmm_address), 64'(cur.addr));
                  if (cur.wr) chk("bus_wdata", 64'(bus_if.avmm_writedata), 64'(cur.wdata));
               end
               len = 0;
            end
            if (s) len++;
            if (!s && prev_s) chk("bus_len", 64'(len), 64'(cur.len));
            prev_s = s;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t f;
      int  start, n;
      bus_if.avsi_valid = 1'b0;
      bus_if.avsi_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_avso_valid", 64'(bus_if.avso_valid), 64'd0);
      chk("rst_avso_data", 64'(bus_if.avso_data), 64'd0);
      chk("rst_write", 64'(bus_if.avmm_write), 64'd0);
      chk("rst_read", 64'(bus_if.avmm_read), 64'd0);
      chk("rst_addr", 64'(bus_if.avmm_address), 64'd0);
      chk("rst_wdata", 64'(bus_if.avmm_writedata), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_avsi_ready", 64'(bus_if.avsi_ready), 64'd1);

      // Plain write.
      ws_target = 0;
      push_bus(1'b1, 32'h10, 32'hDEADBEEF, 1);
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
      send_frame(mk_frame(8'h01, 32'h10, 32'hDEADBEEF, 8'h00), 0);
      wait_drain("write");
      chk("addr_hold", 64'(bus_if.avmm_address), 64'h10);
      chk("wdata_hold", 64'(bus_if.avmm_writedata), 64'hDEADBEEF);

      // Read with 3 waitrequest cycles.
      ws_target = 3;
      rdata_val = 32'h12345678;
      push_bus(1'b0, 32'h20, 32'h0, 4);
      push_read_rsp(32'h12345678);
      send_frame(mk_frame(8'h02, 32'h20, 32'h0, 8'h00), 0);
      wait_drain("read");

      // Corrupted CRC: status 01, CRC8(01)=07, no bus access.
      ws_target = 0;
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h01); rsp_q.push_back(8'h07);
      send_frame(mk_frame(8'h01, 32'h10, 32'hDEADBEEF, 8'h01), 0);
      wait_drain("crc_err");

      // Abandoned frame after 3 addr bytes, then a good frame.
      send_byte(8'hFF, 0); send_byte(8'h01, 0);
      send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      repeat (BYTE_TO + 20) @(negedge clk);
      chk("byte_to_ready", 64'(bus_if.avsi_ready), 64'd1);
      push_bus(1'b1, 32'h44, 32'h0BADF00D, 1);
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
      send_frame(mk_frame(8'h01, 32'h44, 32'h0BADF00D, 8'h00), 0);
      wait_drain("after_byte_to");

      // Gap just under the byte timeout must not abort the frame.
      rdata_val = 32'hA5A5_0001;
      push_bus(1'b0, 32'h30, 32'h0, 1);
      push_read_rsp(32'hA5A5_0001);
      f = mk_frame(8'h02, 32'h30, 32'h0, 8'h00);
      foreach (f[i]) send_byte(f[i], (i == 5) ? 90 : 0);
      wait_drain("near_byte_to");

      // Bus timeout: strobe held exactly BUS_TO cycles, status 02, CRC8(02)=0E.
      ws_target = 1000;
      push_bus(1'b1, 32'h50, 32'h11223344, BUS_TO);
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h02); rsp_q.push_back(8'h0E);
      send_frame(mk_frame(8'h01, 32'h50, 32'h11223344, 8'h00), 0);
      wait_drain("bus_to");
      ws_target = 0;

      // Unknown command is dropped silently; next frame still parses.
      send_byte(8'hFF, 0); send_byte(8'h05, 0);
      push_bus(1'b1, 32'h000000FF, 32'hFFFFFFFF, 1);
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
      send_frame(mk_frame(8'h01, 32'h000000FF, 32'hFFFFFFFF, 8'h00), 0);
      wait_drain("bad_cmd_then_sync_payload");

      // Random backpressure and inbound gaps.
      rand_ready = 1'b1;
      ws_target  = 2;
      rdata_val  = 32'h8001_7F00;
      push_bus(1'b0, 32'hFFFF_FF00, 32'h0, 3);
      push_read_rsp(32'h8001_7F00);
      send_frame(mk_frame(8'h02, 32'hFFFF_FF00, 32'h0, 8'h00), 3);
      push_bus(1'b1, 32'h0000_1234, 32'h0102_0304, 3);
      rsp_q.push_back(8'hFE); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
      send_frame(mk_frame(8'h01, 32'h0000_1234, 32'h0102_0304, 8'h00), 3);
      wait_drain("random");

      // Reset in the middle of the read-data bytes.
      ws_target = 0;
      rdata_val = 32'hCAFE_F00D;
      push_bus(1'b0, 32'h60, 32'h0, 1);
      push_read_rsp(32'hCAFE_F00D);
      start = rx_cnt;
      send_frame(mk_frame(8'h02, 32'h60, 32'h0, 8'h00), 2);
      n = 0;
      while (rx_cnt < start + 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_evt("mid_rsp_wait", "response bytes not seen within 3000 cycles");
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      rsp_q.delete();
      #1;
      chk("midrst_avso_valid", 64'(bus_if.avso_valid), 64'd0);
      chk("midrst_strobes", 64'({bus_if.avmm_write, bus_if.avmm_read}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("midrst_avsi_ready", 64'(bus_if.avsi_ready), 64'd1);
      chk("midrst_idle_valid", 64'(bus_if.avso_valid), 64'd0);
      rdata_val = 32'h5566_7788;
      push_bus(1'b0, 32'h64, 32'h0, 1);
      push_read_rsp(32'h5566_7788);
      send_frame(mk_frame(8'h02, 32'h64, 32'h0, 8'h00), 2);
      wait_drain("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
